// File: rtl/velocity_pkg.sv
// Shared constants for the velocity stepper: FSM encoding and datapath widths.
package velocity_pkg;

  localparam int unsigned VEL_W = 6;   // velocity word width
  localparam int unsigned ACC_W = 11;  // accumulator width, holds ACC_LIMIT-1 + 63

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/velocity_stepper_if.sv
// Control/status bundle between the velocity source, the stepper and the display logic.
interface velocity_stepper_if #(
  parameter int unsigned POS_BITS = 10
) ();
  import velocity_pkg::*;

  logic                vel_strobe;
  logic [VEL_W-1:0]    velocity;
  logic                start;
  logic                stop;
  logic [POS_BITS-1:0] position;
  logic                moving;
  logic                step_pulse;
  logic                wrap_pulse;
  logic                dir;

  // Source/controller side
  modport master (
    output vel_strobe, velocity, start, stop,
    input  position, moving, step_pulse, wrap_pulse, dir
  );

  // Stepper side
  modport slave (
    input  vel_strobe, velocity, start, stop,
    output position, moving, step_pulse, wrap_pulse, dir
  );

endinterface

// File: rtl/velocity_stepper_tick_divider.sv
// Free-running divider producing a one-cycle integration tick every TICK_MOD clocks.
module tick_divider #(
  parameter int unsigned TICK_MOD = 50000
) (
  input  logic CLK_50MHz,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_MOD > 1) ? $clog2(TICK_MOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_MOD - 1);

  logic [CNT_W-1:0] r_count;

  assign tick = (r_count == CNT_LAST);

  // Count 0..TICK_MOD-1 and wrap on the tick cycle
  always_ff @(posedge CLK_50MHz) begin
    if (reset) begin
      r_count <= '0;
    end else if (tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/velocity_stepper.sv
// Velocity stepper: integrates a strobed 6-bit velocity into a wrapping (or bouncing) position.
// Optional feature macro: BOUNCE_EN (reverse direction at the ends instead of wrapping).
module velocity_stepper
  import velocity_pkg::*;
#(
  parameter int unsigned TICK_MOD  = 50000,
  parameter int unsigned ACC_LIMIT = 1000,
  parameter int unsigned POS_MAX   = 639,
  parameter int unsigned POS_BITS  = 10
) (
  input  logic               CLK_50MHz,
  input  logic               reset,
  velocity_stepper_if.slave  bus
);

  localparam logic [ACC_W-1:0]    ACC_LIM  = ACC_W'(ACC_LIMIT);
  localparam logic [POS_BITS-1:0] POS_LAST = POS_BITS'(POS_MAX);

  logic                r_s1, r_s2, r_s3;
  logic                w_load;
  logic [VEL_W-1:0]    r_vel_q;
  logic [0:0]          r_state, w_state_d;
  logic                w_tick;
  logic [ACC_W-1:0]    r_acc, w_sum;
  logic                w_run_tick, w_step;
  logic [POS_BITS-1:0] r_pos, w_pos_d;
  logic                r_dir, w_dir_d, w_wrap_d;
  logic                r_step_pulse, r_wrap_pulse;

  tick_divider #(
    .TICK_MOD (TICK_MOD)
  ) u_tick (
    .CLK_50MHz (CLK_50MHz),
    .reset     (reset),
    .tick      (w_tick)
  );

  // Strobe synchroniser plus rising-edge detect; velocity captured on the edge cycle
  always_ff @(posedge CLK_50MHz) begin
    if (reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_vel_q <= '0;
    end else begin
      r_s1 <= bus.vel_strobe;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (w_load) r_vel_q <= bus.velocity;
    end
  end

  assign w_load = r_s2 & ~r_s3;

  // Next-state: stop wins over a simultaneous start
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_IDLE: if (bus.start && !bus.stop) w_state_d = ST_RUN;
      ST_RUN:  if (bus.stop) w_state_d = ST_IDLE;
      default: w_state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK_50MHz) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_d;
  end

  // Old vel_q is used even when a load lands on the tick cycle
  assign w_sum      = r_acc + ACC_W'(r_vel_q);
  assign w_run_tick = (r_state == ST_RUN) && w_tick;
  assign w_step     = w_run_tick && (w_sum >= ACC_LIM);

  // Next position/direction for a step
  always_comb begin
    w_pos_d  = r_pos;
    w_dir_d  = r_dir;
    w_wrap_d = 1'b0;
`ifdef BOUNCE_EN
    if (!r_dir) begin
      if (r_pos == POS_LAST) begin
        w_pos_d  = POS_LAST - POS_BITS'(1);
        w_dir_d  = 1'b1;
        w_wrap_d = 1'b1;
      end else begin
        w_pos_d = r_pos + POS_BITS'(1);
      end
    end else begin
      if (r_pos == '0) begin
        w_pos_d  = POS_BITS'(1);
        w_dir_d  = 1'b0;
        w_wrap_d = 1'b1;
      end else begin
        w_pos_d = r_pos - POS_BITS'(1);
      end
    end
`else
    if (r_pos == POS_LAST) begin
      w_pos_d  = '0;
      w_wrap_d = 1'b1;
    end else begin
      w_pos_d = r_pos + POS_BITS'(1);
    end
`endif
  end

  // Accumulator, position and output pulses
  always_ff @(posedge CLK_50MHz) begin
    if (reset) begin
      r_acc        <= '0;
      r_pos        <= '0;
      r_dir        <= 1'b0;
      r_step_pulse <= 1'b0;
      r_wrap_pulse <= 1'b0;
    end else begin
      r_step_pulse <= w_step;
      r_wrap_pulse <= w_step & w_wrap_d;
      if (w_run_tick) r_acc <= w_step ? (w_sum - ACC_LIM) : w_sum;
      if (w_step) begin
        r_pos <= w_pos_d;
        r_dir <= w_dir_d;
      end
    end
  end

  assign bus.position   = r_pos;
  assign bus.moving     = (r_state == ST_RUN);
  assign bus.step_pulse = r_step_pulse;
  assign bus.wrap_pulse = r_wrap_pulse;
  assign bus.dir        = r_dir;

endmodule

// File: tb/tb_velocity_stepper.sv
// Directed bench for velocity_stepper with TICK_MOD=4, ACC_LIMIT=100, POS_MAX=7.
module tb_velocity_stepper;
  import velocity_pkg::*;

  localparam int unsigned POS_BITS = 3;

  logic CLK_50MHz = 1'b0;
  logic reset     = 1'b1;
  int   n_checks  = 0;
  int   n_fail    = 0;

  velocity_stepper_if #(.POS_BITS(POS_BITS)) bus ();

  velocity_stepper #(
    .TICK_MOD  (4),
    .ACC_LIMIT (100),
    .POS_MAX   (7),
    .POS_BITS  (POS_BITS)
  ) dut (
    .CLK_50MHz (CLK_50MHz),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 CLK_50MHz = ~CLK_50MHz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK_50MHz);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic load_vel(input logic [5:0] v);
    bus.vel_strobe = 1'b0;
    cycles(3);
    bus.velocity   = v;
    bus.vel_strobe = 1'b1;
    cycles(4);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
  endtask

  // Advance until step_pulse is seen or the budget runs out
  task automatic wait_step(input int max, output int n, output bit found);
    n     = 0;
    found = 1'b0;
    while (n < max && !found) begin
      cyc();
      n++;
      if (bus.step_pulse) found = 1'b1;
    end
  endtask

  // Let nt RUN ticks be integrated, issuing stop alongside the last one
  task automatic run_ticks(input int nt, output int steps, output bit ok);
    int seen;
    seen  = 0;
    steps = 0;
    ok    = 1'b0;
    for (int g = 0; g < nt * 8 && !ok; g++) begin
      if (dut.w_tick && bus.moving) begin
        seen++;
        if (seen == nt) begin
          bus.stop = 1'b1;
          ok       = 1'b1;
        end
      end
      cyc();
      bus.stop = 1'b0;
      if (bus.step_pulse) steps++;
    end
  endtask

  initial begin
    int          n;
    bit          found;
    int          steps;
    logic [31:0] hold_pos, hold_acc;

    bus.vel_strobe = 1'b0;
    bus.velocity   = '0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    cycles(3);
    reset = 1'b0;

    // Reset state
    check("rst_position", 32'(bus.position), 0);
    check("rst_moving", 32'(bus.moving), 0);
    check("rst_step", 32'(bus.step_pulse), 0);
    check("rst_wrap", 32'(bus.wrap_pulse), 0);
    check("rst_dir", 32'(bus.dir), 0);

    // velocity=50: one step every 2 ticks = 8 cycles
    load_vel(6'd50);
    check("v50_velq", 32'(dut.r_vel_q), 50);
    pulse_start();
    check("v50_moving", 32'(bus.moving), 1);
    wait_step(40, n, found);
    check("v50_first_found", 32'(found), 1);
    check("v50_pos1", 32'(bus.position), 1);
    wait_step(20, n, found);
    check("v50_period_a", 32'(n), 8);
    check("v50_pos2", 32'(bus.position), 2);
    wait_step(20, n, found);
    check("v50_period_b", 32'(n), 8);
    check("v50_pos3", 32'(bus.position), 3);
    wait_step(20, n, found);
    wait_step(20, n, found);
    check("v50_pos5", 32'(bus.position), 5);

    // Reset mid-run
    reset = 1'b1;
    bus.vel_strobe = 1'b0;
    cyc();
    check("midrst_position", 32'(bus.position), 0);
    check("midrst_moving", 32'(bus.moving), 0);
    check("midrst_step", 32'(bus.step_pulse), 0);
    check("midrst_state", 32'(dut.r_state), 32'(ST_IDLE));
    check("midrst_velq", 32'(dut.r_vel_q), 0);
    check("midrst_acc", 32'(dut.r_acc), 0);
    reset = 1'b0;

    // velocity=35 for 20 ticks: 700/100 = 7 steps, acc back to 0
    load_vel(6'd35);
    pulse_start();
    run_ticks(20, steps, found);
    check("v35_ticks_done", 32'(found), 1);
    check("v35_steps", 32'(steps), 7);
    check("v35_position", 32'(bus.position), 7);
    check("v35_acc", 32'(dut.r_acc), 0);
    check("v35_moving", 32'(bus.moving), 0);

    // Step due at position 7
    pulse_start();
    wait_step(40, n, found);
    check("wrap_found", 32'(found), 1);
`ifdef BOUNCE_EN
    check("wrap_position", 32'(bus.position), 6);
    check("wrap_dir", 32'(bus.dir), 1);
`else
    check("wrap_position", 32'(bus.position), 0);
    check("wrap_dir", 32'(bus.dir), 0);
`endif
    check("wrap_pulse", 32'(bus.wrap_pulse), 1);
    cyc();
    check("wrap_pulse_end", 32'(bus.wrap_pulse), 0);
    check("step_pulse_end", 32'(bus.step_pulse), 0);
`ifdef BOUNCE_EN
    for (int i = 0; i < 6; i++) wait_step(40, n, found);
    check("bounce_at0", 32'(bus.position), 0);
    check("bounce_down_dir", 32'(bus.dir), 1);
    wait_step(40, n, found);
    check("bounce_low_pos", 32'(bus.position), 1);
    check("bounce_low_dir", 32'(bus.dir), 0);
    check("bounce_low_wrap", 32'(bus.wrap_pulse), 1);
`else
    wait_step(40, n, found);
    check("after_wrap_pos", 32'(bus.position), 1);
    check("after_wrap_nowrap", 32'(bus.wrap_pulse), 0);
`endif
    pulse_stop();
    check("stopped", 32'(bus.moving), 0);

    // start+stop together in IDLE: stop wins
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("startstop_moving", 32'(bus.moving), 0);
    cycles(10);
    check("startstop_moving_later", 32'(bus.moving), 0);
    check("startstop_pos_held", 32'(bus.position), 1);

    // acc=40 after stop, restart with velocity=60: step on first tick
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    load_vel(6'd20);
    pulse_start();
    run_ticks(2, steps, found);
    check("acc40_steps", 32'(steps), 0);
    check("acc40_acc", 32'(dut.r_acc), 40);
    load_vel(6'd60);
    check("acc40_acc_idle", 32'(dut.r_acc), 40);
    check("v60_velq", 32'(dut.r_vel_q), 60);
    pulse_start();
    steps = 0;
    found = 1'b0;
    for (int g = 0; g < 16 && !found; g++) begin
      if (dut.w_tick && bus.moving) found = 1'b1;
      cyc();
      if (!found && bus.step_pulse) steps++;
    end
    check("restart_tick_seen", 32'(found), 1);
    check("restart_early_steps", 32'(steps), 0);
    check("restart_step", 32'(bus.step_pulse), 1);
    check("restart_position", 32'(bus.position), 1);
    check("restart_acc", 32'(dut.r_acc), 0);

    // velocity 20 -> 0 during RUN: motion stops, acc frozen
    load_vel(6'd20);
    cycles(30);
    load_vel(6'd0);
    check("v0_velq", 32'(dut.r_vel_q), 0);
    hold_pos = 32'(bus.position);
    hold_acc = 32'(dut.r_acc);
    steps = 0;
    for (int g = 0; g < 40; g++) begin
      cyc();
      if (bus.step_pulse) steps++;
    end
    check("v0_moving", 32'(bus.moving), 1);
    check("v0_steps", 32'(steps), 0);
    check("v0_pos_held", 32'(bus.position), hold_pos);
    check("v0_acc_held", 32'(dut.r_acc), hold_acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
